// File: rtl/bsg_compare_and_unswap_if.sv
// Handshake bundle for bsg_compare_and_unswap: flag push, returning pair,
// restored output pair and flag occupancy.
interface bsg_compare_and_unswap_if #(
  parameter int width_p = 64,
  parameter int els_p   = 8
);

  logic                         swap_v_i;
  logic                         swapped_i;
  logic                         swap_ready_o;
  logic                         data_v_i;
  logic [2*width_p-1:0]         data_i;
  logic                         data_ready_o;
  logic                         v_o;
  logic [2*width_p-1:0]         data_o;
  logic                         ready_i;
  logic [$clog2(els_p+1)-1:0]   count_o;

  // block side
  modport slave (
    input  swap_v_i,
    input  swapped_i,
    output swap_ready_o,
    input  data_v_i,
    input  data_i,
    output data_ready_o,
    output v_o,
    output data_o,
    input  ready_i,
    output count_o
  );

  // producer/consumer side
  modport master (
    output swap_v_i,
    output swapped_i,
    input  swap_ready_o,
    output data_v_i,
    output data_i,
    input  data_ready_o,
    input  v_o,
    input  data_o,
    output ready_i,
    input  count_o
  );

endinterface

// File: rtl/bsg_compare_and_unswap.sv
// Queues forward-path swap flags and restores returning pairs to lane order.
// Optional same-cycle flag bypass: BSG_COMPARE_AND_UNSWAP_BYPASS_EN.
module bsg_compare_and_unswap #(
  parameter int width_p = 64,
  parameter int els_p   = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bsg_compare_and_unswap_if.slave io
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);
  localparam int pw    = 2 * width_p;

  logic [els_p-1:0] flags_r;
  logic [ptr_w-1:0] rptr_r;
  logic [ptr_w-1:0] wptr_r;
  logic [cnt_w-1:0] count_r;
  logic             v_r;
  logic [pw-1:0]    data_r;

  logic          full;
  logic          empty;
  logic          out_free;
  logic          bypass;
  logic          data_ready;
  logic          swap_ready;
  logic          accept;
  logic          push;
  logic          pop;
  logic          head;
  logic [pw-1:0] restored;

  assign full     = (count_r == cnt_w'(els_p));
  assign empty    = (count_r == '0);
  assign out_free = !v_r || io.ready_i;

`ifdef BSG_COMPARE_AND_UNSWAP_BYPASS_EN
  // empty queue: an incoming flag may serve a same-cycle pair
  assign bypass = empty && io.swap_v_i;
`else
  assign bypass = 1'b0;
`endif

  assign swap_ready = !full;
  assign data_ready = (!empty || bypass) && out_free;

  assign accept = io.data_v_i && data_ready;
  assign pop    = accept && !bypass;
  assign push   = io.swap_v_i && swap_ready
                  && !(bypass && accept);

  assign head = bypass ? io.swapped_i
                       : flags_r[rptr_r];

  assign restored = head
    ? {io.data_i[width_p-1:0], io.data_i[pw-1:width_p]}
    : io.data_i;

  assign io.swap_ready_o = swap_ready;
  assign io.data_ready_o = data_ready;
  assign io.v_o          = v_r;
  assign io.data_o       = data_r;
  assign io.count_o      = count_r;

  // flag storage write port
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      flags_r <= '0;
    end else if (push) begin
      flags_r[wptr_r] <= io.swapped_i;
    end
  end

  // pointers wrap naturally; occupancy tracks push/pop
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr_r <= wptr_r + 1'b1;
      if (pop)  rptr_r <= rptr_r + 1'b1;
      unique case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // single-entry output register with drain/load overlap
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_r    <= 1'b0;
      data_r <= '0;
    end else if (accept) begin
      v_r    <= 1'b1;
      data_r <= restored;
    end else if (io.ready_i) begin
      v_r    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bsg_compare_and_unswap.sv
// Directed + random bench for bsg_compare_and_unswap with a queue model.
// Build with BSG_COMPARE_AND_UNSWAP_BYPASS_EN to exercise the bypass model.
module tb_bsg_compare_and_unswap;

  localparam int W = 64;
  localparam int E = 8;

  logic clk = 0;
  logic rst_n = 0;

  always #5 clk = ~clk;

  bsg_compare_and_unswap_if #(.width_p(W), .els_p(E)) io ();

  bsg_compare_and_unswap #(.width_p(W), .els_p(E)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .io        (io)
  );

  int total = 0;
  int bad   = 0;

  bit           q[$];
  bit           mv;
  logic [127:0] md;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] pr(input logic [63:0] a,
                                     input logic [63:0] b);
    return {a, b};
  endfunction

  // One cycle: drive, check handshake, advance model, check registers.
  task automatic step(input bit sv, input bit sw, input bit dv,
                      input logic [127:0] d, input bit rdy);
    bit esr, edr, byp, acc, push, flag;
    io.swap_v_i  = sv;
    io.swapped_i = sw;
    io.data_v_i  = dv;
    io.data_i    = d;
    io.ready_i   = rdy;
    #1;
    esr = (q.size() != E);
    byp = 0;
`ifdef BSG_COMPARE_AND_UNSWAP_BYPASS_EN
    byp = (q.size() == 0) && sv;
`endif
    edr = ((q.size() != 0) || byp) && (!mv || rdy);
    chk("swap_ready", 128'(io.swap_ready_o), 128'(esr));
    chk("data_ready", 128'(io.data_ready_o), 128'(edr));
    acc  = dv && edr;
    push = sv && esr;
    flag = 0;
    if (acc) begin
      if (byp) begin
        flag = sw;
        push = 0;
      end else begin
        flag = q.pop_front();
      end
    end
    if (push) q.push_back(sw);
    if (acc) begin
      mv = 1;
      md = flag ? {d[63:0], d[127:64]} : d;
    end else if (rdy) begin
      mv = 0;
    end
    @(posedge clk);
    #1;
    chk("v_o", 128'(io.v_o), 128'(mv));
    chk("data_o", io.data_o, md);
    chk("count_o", 128'(io.count_o), 128'(q.size()));
  endtask

  initial begin
    logic [127:0] d1;
    logic [127:0] d2;
    io.swap_v_i  = 0;
    io.swapped_i = 0;
    io.data_v_i  = 0;
    io.data_i    = '0;
    io.ready_i   = 1;
    mv = 0;
    md = '0;

    // reset values
    #3;
    chk("rst_v", 128'(io.v_o), 128'(0));
    chk("rst_data", io.data_o, 128'(0));
    chk("rst_count", 128'(io.count_o), 128'(0));
    chk("rst_sready", 128'(io.swap_ready_o), 128'(1));
    chk("rst_dready", 128'(io.data_ready_o), 128'(0));
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // basic ordering
    step(1, 1, 0, '0, 1);
    step(1, 0, 0, '0, 1);
    step(0, 0, 1, pr(64'd5, 64'd3), 1);
    chk("basic0", io.data_o, pr(64'd3, 64'd5));
    step(0, 0, 1, pr(64'd2, 64'd9), 1);
    chk("basic1", io.data_o, pr(64'd2, 64'd9));
    step(0, 0, 0, '0, 1);

    // full FIFO, then refused 9th push during an accept
    for (int i = 0; i < E; i++) step(1, 1'($urandom), 0, '0, 1);
    chk("full_count", 128'(io.count_o), 128'(E));
    chk("full_sready", 128'(io.swap_ready_o), 128'(0));
    step(1, 1, 1, rnd128(), 1);
    chk("ninth_count", 128'(io.count_o), 128'(E - 1));
    for (int i = 0; i < E - 1; i++) step(0, 0, 1, rnd128(), 1);
    step(0, 0, 0, '0, 1);

    // empty FIFO holds off data
    d1 = rnd128();
    for (int i = 0; i < 3; i++) step(0, 0, 1, d1, 1);
    step(1, 1, 1, d1, 1);
    step(0, 0, 1, d1, 1);
`ifndef BSG_COMPARE_AND_UNSWAP_BYPASS_EN
    chk("empty_swap", io.data_o, {d1[63:0], d1[127:64]});
`endif
    step(0, 0, 0, '0, 1);

    // backpressure
    d1 = rnd128();
    d2 = rnd128();
    step(1, 0, 0, '0, 1);
    step(1, 1, 1, d1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, d2, 0);
    chk("bp_hold", io.data_o, d1);
    step(0, 0, 1, d2, 1);
    chk("bp_reload_v", 128'(io.v_o), 128'(1));
    step(0, 0, 0, '0, 1);

    // full-rate random stream, pointers wrap
    for (int i = 0; i < 22; i++)
      step(i < 20, 1'($urandom), i > 0, rnd128(), 1);
    for (int i = 0; i < 30; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom),
           rnd128(), ($urandom_range(3) != 0));
    while (q.size() != 0) step(0, 0, 1, rnd128(), 1);
    step(0, 0, 0, '0, 1);

    // mid-stream reset
    for (int i = 0; i < 5; i++) step(1, 1'($urandom), 0, '0, 1);
    step(0, 0, 1, rnd128(), 0);
    chk("pre_rst_count", 128'(io.count_o), 128'(4));
    io.data_v_i = 0;
    io.swap_v_i = 0;
    #2;
    rst_n = 0;
    #1;
    q.delete();
    mv = 0;
    md = '0;
    chk("mrst_v", 128'(io.v_o), 128'(0));
    chk("mrst_count", 128'(io.count_o), 128'(0));
    chk("mrst_data", io.data_o, 128'(0));
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(0, 0, 1, rnd128(), 1);
    step(1, 0, 0, '0, 1);
    step(0, 0, 1, rnd128(), 1);
    step(0, 0, 0, '0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
